// File: rtl/task_12_deserializer_if.sv
// Serial-in / frame-out bus for the task_12 deserializer.
// The slave modport is the deserializer's view and the master modport is the environment's view.
interface task_12_deserializer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_OUT      = 3
);
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_data [N_OUT];
    logic                  o_valid;
    logic                  o_err;
    logic                  o_overflow;
    logic [15:0]           o_err_cnt;

    modport slave (
        input  i_data, i_valid, i_ready,
        output o_data, o_valid, o_err, o_overflow, o_err_cnt
    );

    modport master (
        output i_data, i_valid, i_ready,
        input  o_data, o_valid, o_err, o_overflow, o_err_cnt
    );
endinterface

// File: rtl/task_12_deserializer.sv
// Gathers N_OUT consecutive serial words into one frame and presents it on a valid/ready output register.
// Frames broken by a gap raise o_err. Frames that complete while the output is blocked are dropped and raise o_overflow.
module task_12_deserializer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_OUT      = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    task_12_deserializer_if.slave bus
);
    localparam int unsigned CW = $clog2(N_OUT);
    localparam int unsigned EW = 16;

    typedef enum logic {IDLE, COLLECT} state_e;

    state_e                state_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] buf_q   [N_OUT-1];
    logic [DATA_WIDTH-1:0] data_q  [N_OUT];
    logic                  valid_q;
    logic                  err_q;
    logic                  ovf_q;
    logic [EW-1:0]         err_cnt_q;

    logic                  complete_c;
    logic [DATA_WIDTH-1:0] frame_c [N_OUT];

    // The last word goes straight from the input into the frame, with no buffer hop.
    always_comb begin
        complete_c = (state_q == COLLECT) && bus.i_valid && (cnt_q == CW'(N_OUT - 1));
        for (int i = 0; i < int'(N_OUT) - 1; i++) frame_c[i] = buf_q[i];
        frame_c[N_OUT-1] = bus.i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            err_cnt_q <= '0;
            for (int i = 0; i < int'(N_OUT); i++) data_q[i] <= '0;
            for (int i = 0; i < int'(N_OUT) - 1; i++) buf_q[i] <= '0;
        end else begin
            err_q <= 1'b0;
            ovf_q <= 1'b0;

            // The output register reloads when it is empty or being drained on this same edge.
            if (complete_c) begin
                if (!valid_q || bus.i_ready) begin
                    data_q  <= frame_c;
                    valid_q <= 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                end
            end else if (valid_q && bus.i_ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (bus.i_valid) begin
                        buf_q[0] <= bus.i_data;
                        cnt_q    <= CW'(1);
                        state_q  <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (bus.i_valid) begin
                        if (complete_c) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            for (int i = 0; i < int'(N_OUT) - 1; i++) begin
                                if (cnt_q == CW'(i)) buf_q[i] <= bus.i_data;
                            end
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end else begin
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (err_cnt_q != {EW{1'b1}}) err_cnt_q <= err_cnt_q + EW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_data     = data_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_err      = err_q;
    assign bus.o_overflow = ovf_q;
    assign bus.o_err_cnt  = err_cnt_q;
endmodule
